mult_operand_sequencer: RTL and testbench

MULT_OPERAND_SEQUENCER -- requirements
Module: mult_operand_sequencer

---
 rtl/mult_seq_pkg.sv | 17 +
 rtl/mult_operand_fifo.sv | 66 ++++++
 rtl/mult_operand_sequencer.sv | 159 +++++++++++++++
 tb/tb_mult_operand_sequencer.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_seq_pkg.sv
// mult_seq_pkg
//   Shared definitions for the multiplier operand sequencer: sequencer FSM
//   state encoding, operand/product widths and the default multiplier
//   response timeout.
package mult_seq_pkg;

   localparam int OPW                 = 4;   // operand width
   localparam int PRODW               = 8;   // product width
   localparam int TIMEOUT_CYC_DEFAULT = 64;  // WAIT cycles before giving up

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

endpackage

// File: rtl/mult_operand_fifo.sv
// mult_operand_fifo
//   Synchronous FIFO holding DEPTH words of WIDTH bits. No bypass: a word
//   pushed this cycle is visible at the head from the next cycle on, and a
//   full FIFO reports full even in a cycle that pops.
// Ports:
//   clk, reset  - clock, synchronous active-high reset (empties the FIFO)
//   push        - write push_data (ignored while full)
//   push_data   - word to write
//   pop         - discard the head word (ignored while empty)
//   head_data   - oldest stored word, valid while empty is low
//   full, empty - occupancy flags
module mult_operand_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign do_push   = push && !full;
   assign do_pop    = pop && !empty;
   assign full      = (count == (AW+1)'(DEPTH));
   assign empty     = (count == '0);
   assign head_data = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of block ordering.
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; the pointers and count define
   // which entries are meaningful, and an unreset array maps to plain RAM.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/mult_operand_sequencer.sv
// mult_operand_sequencer
//   Queues {op_a, op_b} pairs from a producer, issues them one at a time to
//   an external 4x4 multiplier (one-cycle mul_start pulse, operands held
//   until the product returns), and presents each product to a consumer
//   through a single result slot. A new operation is only issued when the
//   result slot is free, so a held result is never overwritten.
// Configuration macro:
//   MULT_TIMEOUT_EN - when defined, an operation left unanswered for
//                     TIMEOUT_CYC WAIT cycles is dropped and the sticky
//                     timeout_err flag is set. Undefined: waits forever.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   op_a, op_b, op_valid  - producer operand pair offer
//   op_ready              - queue not full (pair taken on valid & ready)
//   mul_a, mul_b          - operands to the multiplier
//   mul_start             - one-cycle start pulse to the multiplier
//   mul_done, mul_product - multiplier completion and product
//   res_product, res_valid, res_ready - result slot to the consumer
//   busy                  - FSM not idle or operands queued
//   timeout_err           - sticky multiplier-timeout flag
module mult_operand_sequencer
   import mult_seq_pkg::*;
#(
   parameter int DEPTH       = 4,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [OPW-1:0]   op_a,
   input  logic [OPW-1:0]   op_b,
   input  logic             op_valid,
   output logic             op_ready,
   output logic [OPW-1:0]   mul_a,
   output logic [OPW-1:0]   mul_b,
   output logic             mul_start,
   input  logic             mul_done,
   input  logic [PRODW-1:0] mul_product,
   output logic [PRODW-1:0] res_product,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             busy,
   output logic             timeout_err
);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_param_check
      $error("mult_operand_sequencer: DEPTH must be a power of two >= 2 and TIMEOUT_CYC >= 1");
   end

   state_t             state;
   state_t             state_next;
   logic               fifo_push;
   logic               fifo_pop;
   logic               fifo_full;
   logic               fifo_empty;
   logic [2*OPW-1:0]   head_pair;
   logic               slot_free;
   logic               capture;
   logic               timeout_hit;

   assign op_ready  = !fifo_full;
   assign fifo_push = op_valid && !fifo_full;
   // The slot counts as free when the consumer takes the held result this cycle.
   assign slot_free = !res_valid || res_ready;
   assign busy      = (state != S_IDLE) || !fifo_empty;

   mult_operand_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (2*OPW)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push),
      .push_data ({op_a, op_b}),
      .pop       (fifo_pop),
      .head_data (head_pair),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves a signal unassigned, which would infer a latch.
      state_next = state;
      fifo_pop   = 1'b0;
      mul_start  = 1'b0;
      capture    = 1'b0;
      case (state)
         S_IDLE: begin
            if (!fifo_empty && slot_free) begin
               fifo_pop   = 1'b1;
               state_next = S_ISSUE;
            end
         end
         S_ISSUE: begin
            mul_start  = 1'b1;
            state_next = S_WAIT;
         end
         S_WAIT: begin
            if (mul_done) begin
               capture    = 1'b1;
               state_next = S_IDLE;
            end else if (timeout_hit) begin
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Operands change only on a pop, so they stay stable through ISSUE/WAIT.
   always_ff @(posedge clk) begin
      if (reset) begin
         mul_a       <= '0;
         mul_b       <= '0;
         res_product <= '0;
         res_valid   <= 1'b0;
      end else begin
         if (fifo_pop) {mul_a, mul_b} <= head_pair;
         if (capture) begin
            res_product <= mul_product;
            res_valid   <= 1'b1;
         end else if (res_ready) begin
            res_valid   <= 1'b0;
         end
      end
   end

`ifdef MULT_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic [TW-1:0] wait_cnt;
   logic          timeout_q;

   // Fires in the TIMEOUT_CYC-th consecutive WAIT cycle without mul_done.
   assign timeout_hit = (state == S_WAIT) && !mul_done &&
                        (wait_cnt == TW'(TIMEOUT_CYC - 1));
   assign timeout_err = timeout_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt  <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (state == S_WAIT) wait_cnt <= wait_cnt + 1'b1;
         else                 wait_cnt <= '0;
         if (timeout_hit) timeout_q <= 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mult_operand_sequencer.sv
// tb_mult_operand_sequencer
//   Directed bench for mult_operand_sequencer with a behavioural multiplier,
//   a queue-based reference model checked every cycle, and literal
//   expectations for the directed scenarios.
`timescale 1ns/1ps
module tb_mult_operand_sequencer;

   localparam int DEPTH       = 4;
   localparam int TIMEOUT_CYC = 64;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] op_a, op_b;
   logic       op_valid;
   logic       op_ready;
   logic [3:0] mul_a, mul_b;
   logic       mul_start;
   logic       mul_done;
   logic [7:0] mul_product;
   logic [7:0] res_product;
   logic       res_valid;
   logic       res_ready;
   logic       busy;
   logic       timeout_err;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mult_operand_sequencer #(
      .DEPTH       (DEPTH),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .op_a        (op_a),
      .op_b        (op_b),
      .op_valid    (op_valid),
      .op_ready    (op_ready),
      .mul_a       (mul_a),
      .mul_b       (mul_b),
      .mul_start   (mul_start),
      .mul_done    (mul_done),
      .mul_product (mul_product),
      .res_product (res_product),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural multiplier ----------------
   logic       beh_done   = 1'b0;
   logic [7:0] beh_prod   = 8'd0;
   logic       force_done = 1'b0;
   logic [7:0] force_prod = 8'd0;
   bit         mult_en    = 1'b1;
   int         mult_lat   = 2;

   assign mul_done    = beh_done | force_done;
   assign mul_product = force_done ? force_prod : beh_prod;

   initial begin : beh_mult
      int         cnt;
      bit         pend;
      logic [3:0] pa, pb;
      pend = 1'b0;
      cnt  = 0;
      forever begin
         @(posedge clk); #1;
         beh_done = 1'b0;
         if (reset) begin
            pend = 1'b0;
         end else if (pend) begin
            cnt--;
            if (cnt == 0) begin
               beh_done = 1'b1;
               beh_prod = {4'd0, pa} * {4'd0, pb};
               pend     = 1'b0;
            end
         end else if (mul_start && mult_en) begin
            pend = 1'b1;
            cnt  = mult_lat;
            pa   = mul_a;
            pb   = mul_b;
         end
      end
   end

   // ---------------- reference model + per-cycle compare ----------------
   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
   } pair_t;

   pair_t      pair_q[$];   // accepted, not yet started
   logic [7:0] res_q[$];    // products captured, not yet handed off
   logic [7:0] res_log[$];  // products the DUT handed to the consumer
   bit         op_active  = 1'b0;
   logic [3:0] held_a, held_b;
   int         wait_n     = 0;
   bit         te_exp     = 1'b0;
   bit         prev_start = 1'b0;
   int         start_cnt  = 0;

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (reset) begin
            pair_q.delete();
            res_q.delete();
            op_active  = 1'b0;
            te_exp     = 1'b0;
            prev_start = 1'b0;
         end else begin
            if (mul_start) begin
               check("start_back_to_back", prev_start, 0);
               check("start_during_wait", op_active, 0);
               check("start_has_pair", pair_q.size() != 0, 1);
               if (pair_q.size() != 0) begin
                  check("issue_mul_a", mul_a, pair_q[0].a);
                  check("issue_mul_b", mul_b, pair_q[0].b);
                  void'(pair_q.pop_front());
               end
               start_cnt++;
               op_active = 1'b1;
               wait_n    = 0;
               held_a    = mul_a;
               held_b    = mul_b;
            end else if (op_active) begin
               check("mul_a_stable", mul_a, held_a);
               check("mul_b_stable", mul_b, held_b);
            end
            check("op_ready", op_ready, pair_q.size() < DEPTH);
            check("busy", busy, (pair_q.size() != 0) || op_active);
            check("res_valid", res_valid, res_q.size() != 0);
            if (res_valid && res_q.size() != 0) check("res_product", res_product, res_q[0]);
            check("timeout_err", timeout_err, te_exp);

            // events taking effect at the coming rising edge
            if (res_valid && res_ready && res_q.size() != 0) begin
               void'(res_q.pop_front());
               res_log.push_back(res_product);
            end
            if (op_active && !mul_start) begin
               if (mul_done) begin
                  res_q.push_back({4'd0, held_a} * {4'd0, held_b});
                  op_active = 1'b0;
               end else begin
                  wait_n++;
`ifdef MULT_TIMEOUT_EN
                  if (wait_n == TIMEOUT_CYC) begin
                     op_active = 1'b0;
                     te_exp    = 1'b1;
                  end
`endif
               end
            end
            if (op_valid && op_ready) pair_q.push_back('{op_a, op_b});
            prev_start = mul_start;
         end
      end
   end

   // ---------------- stimulus helpers (called at posedge+1) ----------------
   task automatic push(input logic [3:0] a, input logic [3:0] b);
      bit taken = 1'b0;
      op_a     = a;
      op_b     = b;
      op_valid = 1'b1;
      for (int i = 0; i < 200 && !taken; i++) begin
         @(negedge clk);
         if (op_ready) taken = 1'b1;
         @(posedge clk); #1;
      end
      op_valid = 1'b0;
      check("push_accepted", taken, 1);
   endtask

   task automatic wait_start(output int c);
      bit seen = 1'b0;
      c = -1;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (mul_start) begin
            seen = 1'b1;
            c    = cyc;
         end else begin
            @(posedge clk); #1;
         end
      end
      check("mul_start_seen", seen, 1);
   endtask

   task automatic wait_idle(input int limit);
      bit ok = 1'b0;
      for (int i = 0; i < limit && !ok; i++) begin
         @(posedge clk); #1;
         if (!busy && !res_valid && !mul_done) ok = 1'b1;
      end
      check("idle_reached", ok, 1);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_op_ready"},    op_ready, 1);
      check({tag, "_mul_start"},   mul_start, 0);
      check({tag, "_mul_a"},       mul_a, 0);
      check({tag, "_mul_b"},       mul_b, 0);
      check({tag, "_res_valid"},   res_valid, 0);
      check({tag, "_res_product"}, res_product, 0);
      check({tag, "_busy"},        busy, 0);
      check({tag, "_timeout_err"}, timeout_err, 0);
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   // ---------------- directed scenarios ----------------
   initial begin : stimulus
      int t0, s, e, n0, s0;
      int exp4[4];
      int exp6[6];

      reset    = 1'b1;
      op_valid = 1'b0;
      op_a     = '0;
      op_b     = '0;
      res_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_reset_values("rst");
      @(posedge clk); #1;

      // Single pair (9,6): start two cycles after acceptance, product 54.
      mult_lat = 2;
      n0 = res_log.size();
      t0 = cyc;
      push(4'd9, 4'd6);
      wait_start(s);
      check("t1_latency", s - t0, 2);
      check("t1_mul_a", mul_a, 9);
      check("t1_mul_b", mul_b, 6);
      wait_idle(50);
      check("t1_count", res_log.size() - n0, 1);
      if (res_log.size() > n0) check("t1_product", res_log[n0], 54);

      // Four pairs back to back, including the 15x15 and x0 corners.
      exp4 = '{225, 0, 15, 1};
      n0 = res_log.size();
      s0 = start_cnt;
      push(4'd15, 4'd15);
      push(4'd7, 4'd0);
      push(4'd3, 4'd5);
      push(4'd1, 4'd1);
      wait_idle(100);
      check("t2_starts", start_cnt - s0, 4);
      check("t2_count", res_log.size() - n0, 4);
      for (int i = 0; i < 4; i++)
         if (res_log.size() > n0 + i) check("t2_product", res_log[n0 + i], exp4[i]);

      // Consumer stalled: the slot holds result 1 and the queue fills up.
      exp6 = '{6, 16, 35, 72, 110, 156};
      n0 = res_log.size();
      res_ready = 1'b0;
      push(4'd2, 4'd3);
      push(4'd4, 4'd4);
      push(4'd5, 4'd7);
      push(4'd8, 4'd9);
      push(4'd10, 4'd11);
      repeat (8) @(posedge clk);
      #1;
      check("t3_full_op_ready", op_ready, 0);
      check("t3_held_valid", res_valid, 1);
      check("t3_held_product", res_product, 6);
      op_a = 4'd12;
      op_b = 4'd13;
      op_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("t3_still_full", op_ready, 0);
      check("t3_not_overwritten", res_product, 6);
      res_ready = 1'b1;
      push(4'd12, 4'd13);
      wait_idle(200);
      check("t3_count", res_log.size() - n0, 6);
      for (int i = 0; i < 6; i++)
         if (res_log.size() > n0 + i) check("t3_product", res_log[n0 + i], exp6[i]);

      // mul_done pulsed while idle is ignored.
      s0 = start_cnt;
      force_prod = 8'hAB;
      force_done = 1'b1;
      @(posedge clk); #1;
      force_done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("t4_no_res_valid", res_valid, 0);
      check("t4_not_busy", busy, 0);
      check("t4_product_kept", res_product, 156);
      check("t4_no_start", start_cnt - s0, 0);

      // Reset in WAIT abandons the operation; a stale mul_done is ignored.
      mult_en = 1'b0;
      push(4'd3, 4'd4);
      wait_start(s);
      repeat (3) @(posedge clk);
      #1;
      check("t5_busy_in_wait", busy, 1);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      force_prod = 8'd12;
      force_done = 1'b1;
      @(posedge clk); #1;
      force_done = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_values("t5");
      mult_en = 1'b1;

`ifdef MULT_TIMEOUT_EN
      // Unanswered operation times out after 64 WAIT cycles; next pair runs.
      n0 = res_log.size();
      mult_en = 1'b0;
      push(4'd2, 4'd2);
      push(4'd3, 4'd3);
      wait_start(s);
      @(posedge clk); #1;
      mult_en = 1'b1;
      e = -1;
      for (int i = 0; i < 200 && e < 0; i++) begin
         if (timeout_err) e = cyc;
         else begin
            @(posedge clk); #1;
         end
      end
      check("t6_timeout_cycle", e - s, 65);
      wait_idle(100);
      check("t6_count", res_log.size() - n0, 1);
      if (res_log.size() > n0) check("t6_product", res_log[n0], 9);
      check("t6_sticky", timeout_err, 1);
`else
      // Without the timeout feature WAIT lasts until mul_done arrives.
      n0 = res_log.size();
      mult_en = 1'b0;
      push(4'd4, 4'd5);
      wait_start(s);
      repeat (100) @(posedge clk);
      #1;
      check("t6_still_waiting", busy, 1);
      check("t6_no_timeout", timeout_err, 0);
      force_prod = 8'd20;
      force_done = 1'b1;
      @(posedge clk); #1;
      force_done = 1'b0;
      mult_en = 1'b1;
      wait_idle(50);
      check("t6_count", res_log.size() - n0, 1);
      if (res_log.size() > n0) check("t6_product", res_log[n0], 20);
      e = 0;
`endif

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
